// File: rtl/layer_scheduler_pkg.sv
// Shared definitions for the layer scheduler: state encoding and default widths.
package layer_scheduler_pkg;

   localparam int unsigned KW_DEF = 5;
   localparam int unsigned DW_DEF = 8;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StCfg   = 3'd1,
      StStart = 3'd2,
      StWait  = 3'd3,
      StWb    = 3'd4,
      StAdv   = 3'd5,
      StDone  = 3'd6
   } state_e;

endpackage

// File: rtl/layer_scheduler_nest_counter.sv
// Nested kernel/row/col wrap counter with linear address and last-point flag.
module nest_counter
   import layer_scheduler_pkg::*;
#(
   parameter int unsigned K_W = KW_DEF,
   parameter int unsigned D_W = DW_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 advance,
   input  logic [K_W-1:0]       num_kernel,
   input  logic [D_W-1:0]       rows,
   input  logic [D_W-1:0]       cols,
   output logic [K_W-1:0]       kernel_idx,
   output logic [D_W-1:0]       row_idx,
   output logic [D_W-1:0]       col_idx,
   output logic [K_W+2*D_W-1:0] addr,
   output logic                 last
);

   localparam int unsigned AW = K_W + 2 * D_W;

   logic [K_W-1:0] kernel_q, kernel_d;
   logic [D_W-1:0] row_q, row_d, col_q, col_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic           col_last, row_last, ker_last;

   assign col_last = (col_q == cols - D_W'(1));
   assign row_last = (row_q == rows - D_W'(1));
   assign ker_last = (kernel_q == num_kernel - K_W'(1));

   always_comb begin
      kernel_d = kernel_q;
      row_d    = row_q;
      col_d    = col_q;
      addr_d   = addr_q;
      if (clear) begin
         kernel_d = '0;
         row_d    = '0;
         col_d    = '0;
         addr_d   = '0;
      end else if (advance) begin
         addr_d = addr_q + AW'(1);
         if (col_last) begin
            col_d = '0;
            if (row_last) begin
               row_d    = '0;
               kernel_d = kernel_q + K_W'(1);
            end else begin
               row_d = row_q + D_W'(1);
            end
         end else begin
            col_d = col_q + D_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kernel_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         addr_q   <= '0;
      end else begin
         kernel_q <= kernel_d;
         row_q    <= row_d;
         col_q    <= col_d;
         addr_q   <= addr_d;
      end
   end

   assign kernel_idx = kernel_q;
   assign row_idx    = row_q;
   assign col_idx    = col_q;
   assign addr       = addr_q;
   assign last       = col_last && row_last && ker_last;

endmodule

// File: rtl/layer_scheduler.sv
// Moore FSM sequencing one convolution layer: per-point tile launch, wait, write-back, advance.
module layer_scheduler
   import layer_scheduler_pkg::*;
#(
   parameter int unsigned K_W = KW_DEF,
   parameter int unsigned D_W = DW_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 layer_start,
   input  logic                 abort,
   input  logic [K_W-1:0]       cfg_num_kernel,
   input  logic [D_W-1:0]       cfg_out_rows,
   input  logic [D_W-1:0]       cfg_out_cols,
   output logic                 tile_start,
   input  logic                 tile_done,
   output logic [K_W-1:0]       kernel_idx,
   output logic [D_W-1:0]       row_idx,
   output logic [D_W-1:0]       col_idx,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [K_W+2*D_W-1:0] wb_addr,
   output logic                 busy,
   output logic                 layer_done,
   output logic [2:0]           state_dbg
);

   state_e         state_q, state_d;
   logic [K_W-1:0] cfg_k_q;
   logic [D_W-1:0] cfg_r_q, cfg_c_q;
   logic           cfg_load, abort_hit, cfg_zero, last_pt;

   assign cfg_load  = (state_q == StIdle) && layer_start;
   assign abort_hit = abort && (state_q != StIdle);
   assign cfg_zero  = (cfg_k_q == '0) || (cfg_r_q == '0) || (cfg_c_q == '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (layer_start) state_d = StCfg;
         StCfg:   state_d = cfg_zero ? StDone : StStart;
         StStart: state_d = StWait;
         StWait:  if (tile_done) state_d = StWb;
         StWb:    if (wb_ready) state_d = StAdv;
         StAdv:   state_d = last_pt ? StDone : StStart;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Abort overrides every other transition.
      if (abort_hit) state_d = StIdle;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cfg_k_q <= '0;
         cfg_r_q <= '0;
         cfg_c_q <= '0;
      end else begin
         state_q <= state_d;
         if (cfg_load) begin
            cfg_k_q <= cfg_num_kernel;
            cfg_r_q <= cfg_out_rows;
            cfg_c_q <= cfg_out_cols;
         end
      end
   end

   nest_counter #(
      .K_W (K_W),
      .D_W (D_W)
   ) u_nest_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (cfg_load || abort_hit),
      .advance    ((state_q == StAdv) && !abort),
      .num_kernel (cfg_k_q),
      .rows       (cfg_r_q),
      .cols       (cfg_c_q),
      .kernel_idx (kernel_idx),
      .row_idx    (row_idx),
      .col_idx    (col_idx),
      .addr       (wb_addr),
      .last       (last_pt)
   );

   assign tile_start = (state_q == StStart);
   assign wb_valid   = (state_q == StWb);
   assign busy       = (state_q != StIdle);
   assign layer_done = (state_q == StDone);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed self-checking bench for layer_scheduler.
module tb_layer_scheduler;
   import layer_scheduler_pkg::*;

   localparam int unsigned K_W = KW_DEF;
   localparam int unsigned D_W = DW_DEF;
   localparam int unsigned AW  = K_W + 2 * D_W;

   logic           clk, rst_n, layer_start, abort, tile_done, wb_ready;
   logic [K_W-1:0] cfg_num_kernel;
   logic [D_W-1:0] cfg_out_rows, cfg_out_cols;
   logic           tile_start, wb_valid, busy, layer_done;
   logic [K_W-1:0] kernel_idx;
   logic [D_W-1:0] row_idx, col_idx;
   logic [AW-1:0]  wb_addr;
   logic [2:0]     state_dbg;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   layer_scheduler #(
      .K_W (K_W),
      .D_W (D_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .layer_start    (layer_start),
      .abort          (abort),
      .cfg_num_kernel (cfg_num_kernel),
      .cfg_out_rows   (cfg_out_rows),
      .cfg_out_cols   (cfg_out_cols),
      .tile_start     (tile_start),
      .tile_done      (tile_done),
      .kernel_idx     (kernel_idx),
      .row_idx        (row_idx),
      .col_idx        (col_idx),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_addr        (wb_addr),
      .busy           (busy),
      .layer_done     (layer_done),
      .state_dbg      (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_state(input state_e st, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (state_dbg == st) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Runs one layer with WAIT stall wt and WB stall ww; models the expected point order.
   task automatic run_layer(input int k, input int r, input int c, input int wt, input int ww,
                            input bit poke, output int n_ts, output int n_wb,
                            output int n_done, output int dcyc, output int bad);
      int ek, er, ec, ea, wcnt, bcnt, start;
      bit poked;
      n_ts = 0; n_wb = 0; n_done = 0; dcyc = -1; bad = 0;
      ek = 0; er = 0; ec = 0; ea = 0; wcnt = 0; bcnt = 0; poked = 1'b0;
      @(negedge clk);
      cfg_num_kernel = K_W'(k);
      cfg_out_rows   = D_W'(r);
      cfg_out_cols   = D_W'(c);
      layer_start = 1'b1; tile_done = 1'b0; wb_ready = 1'b0; abort = 1'b0;
      start = cyc;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         layer_start = 1'b0; tile_done = 1'b0; wb_ready = 1'b0;
         if (tile_start) n_ts++;
         if (wb_valid && state_dbg != StWb) bad++;
         if (layer_done) begin
            n_done++;
            dcyc = cyc - start;
            break;
         end
         if (state_dbg == StWait) begin
            tile_done = (wcnt == wt);
            wcnt++;
            if (poke && !poked) begin
               poked = 1'b1;
               layer_start = 1'b1;
               cfg_num_kernel = '1; cfg_out_rows = '1; cfg_out_cols = '1;
            end
         end
         if (state_dbg == StWb) begin
            if (!wb_valid || wb_addr !== AW'(ea) || kernel_idx !== K_W'(ek) ||
                row_idx !== D_W'(er) || col_idx !== D_W'(ec)) bad++;
            wb_ready = (bcnt == ww);
            if (wb_ready) begin
               n_wb++; ea++; ec++;
               if (ec == c) begin
                  ec = 0; er++;
                  if (er == r) begin er = 0; ek++; end
               end
               bcnt = 0; wcnt = 0;
            end else begin
               bcnt++;
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (layer_done) n_done++;
      end
   endtask

   task automatic test_reset();
      bit seen;
      rst_n = 1'b0; layer_start = 1'b0; abort = 1'b0; tile_done = 1'b0; wb_ready = 1'b0;
      cfg_num_kernel = '0; cfg_out_rows = '0; cfg_out_cols = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({tile_start, wb_valid, busy, layer_done} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 0000",
                            {tile_start, wb_valid, busy, layer_done});
      end
      checks++;
      if ({kernel_idx, row_idx, col_idx, wb_addr} !== '0) begin
         errors++; $display("FAIL reset_idx: got k=%0d r=%0d c=%0d a=%0d want 0",
                            kernel_idx, row_idx, col_idx, wb_addr);
      end
      checks++;
      if (state_dbg !== 3'd0) begin
         errors++; $display("FAIL reset_state: got %0d want 0", state_dbg);
      end
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (tile_start || layer_done || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL reset_release: activity seen=%0d want 0", seen);
      end
   endtask

   task automatic test_single_point();
      int n_ts, n_wb, n_done, dcyc, bad;
      run_layer(1, 1, 1, 2, 0, 1'b0, n_ts, n_wb, n_done, dcyc, bad);
      checks++;
      if (n_ts !== 1) begin errors++; $display("FAIL single_ts: got %0d want 1", n_ts); end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL single_seq: bad=%0d want 0", bad); end
      checks++;
      if (dcyc !== 8) begin errors++; $display("FAIL single_lat: got %0d want 8", dcyc); end
   endtask

   task automatic test_multi_point();
      int n_ts, n_wb, n_done, dcyc, bad;
      run_layer(2, 2, 3, 0, 0, 1'b1, n_ts, n_wb, n_done, dcyc, bad);
      checks++;
      if (n_wb !== 12) begin errors++; $display("FAIL multi_wb: got %0d want 12", n_wb); end
      checks++;
      if (n_ts !== 12) begin errors++; $display("FAIL multi_ts: got %0d want 12", n_ts); end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL multi_seq: bad=%0d want 0", bad); end
      checks++;
      if (n_done !== 1) begin errors++; $display("FAIL multi_done: got %0d want 1", n_done); end
      checks++;
      if (dcyc !== 50) begin errors++; $display("FAIL multi_lat: got %0d want 50", dcyc); end
   endtask

   task automatic test_zero_cols();
      int n_ts, n_wb, n_done, dcyc, bad;
      run_layer(1, 1, 0, 0, 0, 1'b0, n_ts, n_wb, n_done, dcyc, bad);
      checks++;
      if (n_ts !== 0 || n_wb !== 0 || bad !== 0) begin
         errors++; $display("FAIL zero_act: ts=%0d wb=%0d bad=%0d want 0/0/0", n_ts, n_wb, bad);
      end
      checks++;
      if (dcyc !== 2) begin errors++; $display("FAIL zero_lat: got %0d want 2", dcyc); end
   endtask

   task automatic test_wb_stall();
      int n_ts, n_wb, n_done, dcyc, bad, stable;
      bit ok;
      @(negedge clk);
      cfg_num_kernel = K_W'(1); cfg_out_rows = D_W'(1); cfg_out_cols = D_W'(1);
      layer_start = 1'b1;
      wait_state(StWait, ok);
      layer_start = 1'b0;
      tile_done = 1'b1;
      if (ok) wait_state(StWb, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_reach: got timeout want WB"); end
      stable = 0;
      for (int j = 0; j < 6; j++) begin
         if (wb_valid && wb_addr == '0 && state_dbg == StWb) stable++;
         wb_ready  = (j == 5);
         tile_done = (j == 2);
         @(negedge clk);
      end
      wb_ready = 1'b0; tile_done = 1'b0;
      checks++;
      if (stable !== 6) begin errors++; $display("FAIL stall_stable: got %0d want 6", stable); end
      checks++;
      if (state_dbg !== StAdv) begin
         errors++; $display("FAIL stall_adv: got %0d want %0d", state_dbg, StAdv);
      end
      @(negedge clk);
      checks++;
      if (layer_done !== 1'b1) begin
         errors++; $display("FAIL stall_done: got %b want 1", layer_done);
      end
      run_layer(1, 2, 2, 1, 5, 1'b0, n_ts, n_wb, n_done, dcyc, bad);
      checks++;
      if (dcyc !== 42 || bad !== 0) begin
         errors++; $display("FAIL stall_lat: got %0d bad=%0d want 42 bad=0", dcyc, bad);
      end
   endtask

   task automatic test_abort();
      int n_ts, n_wb, n_done, dcyc, bad, act;
      bit ok;
      @(negedge clk);
      cfg_num_kernel = K_W'(1); cfg_out_rows = D_W'(1); cfg_out_cols = D_W'(2);
      layer_start = 1'b1; tile_done = 1'b1; wb_ready = 1'b1;
      wait_state(StAdv, ok);
      layer_start = 1'b0; tile_done = 1'b0; wb_ready = 1'b0;
      if (ok) wait_state(StWait, ok);
      checks++;
      if (!ok || wb_addr !== AW'(1)) begin
         errors++; $display("FAIL abort_reach: ok=%0d addr=%0d want 1/1", ok, wb_addr);
      end
      tile_done = 1'b1; abort = 1'b1;
      @(negedge clk);
      tile_done = 1'b0; abort = 1'b0;
      checks++;
      if (state_dbg !== 3'd0 || busy !== 1'b0 || wb_valid !== 1'b0 || layer_done !== 1'b0) begin
         errors++; $display("FAIL abort_idle: state=%0d busy=%b wbv=%b done=%b want 0/0/0/0",
                            state_dbg, busy, wb_valid, layer_done);
      end
      checks++;
      if (wb_addr !== '0 || col_idx !== '0) begin
         errors++; $display("FAIL abort_clr: addr=%0d col=%0d want 0/0", wb_addr, col_idx);
      end
      act = 0;
      repeat (3) begin
         @(negedge clk);
         if (layer_done || wb_valid || busy) act++;
      end
      checks++;
      if (act !== 0) begin errors++; $display("FAIL abort_quiet: got %0d want 0", act); end
      run_layer(1, 1, 2, 0, 0, 1'b0, n_ts, n_wb, n_done, dcyc, bad);
      checks++;
      if (bad !== 0 || n_wb !== 2 || dcyc !== 10) begin
         errors++; $display("FAIL abort_rerun: bad=%0d wb=%0d lat=%0d want 0/2/10",
                            bad, n_wb, dcyc);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      int act;
      @(negedge clk);
      cfg_num_kernel = K_W'(1); cfg_out_rows = D_W'(1); cfg_out_cols = D_W'(3);
      layer_start = 1'b1; tile_done = 1'b1; wb_ready = 1'b1;
      wait_state(StAdv, ok);
      layer_start = 1'b0; wb_ready = 1'b0;
      if (ok) wait_state(StWb, ok);
      checks++;
      if (!ok || wb_addr !== AW'(1) || col_idx !== D_W'(1)) begin
         errors++; $display("FAIL arst_reach: ok=%0d addr=%0d col=%0d want 1/1/1",
                            ok, wb_addr, col_idx);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({tile_start, wb_valid, busy, layer_done, state_dbg} !== '0 ||
          {kernel_idx, row_idx, col_idx, wb_addr} !== '0) begin
         errors++; $display("FAIL arst_outs: wbv=%b busy=%b st=%0d addr=%0d col=%0d want 0",
                            wb_valid, busy, state_dbg, wb_addr, col_idx);
      end
      @(negedge clk);
      rst_n = 1'b1; tile_done = 1'b0; wb_ready = 1'b0;
      act = 0;
      repeat (4) begin
         @(negedge clk);
         if (state_dbg != 3'd0 || tile_start || layer_done) act++;
      end
      checks++;
      if (act !== 0) begin errors++; $display("FAIL arst_idle: got %0d want 0", act); end
   endtask

   initial begin
      test_reset();
      test_single_point();
      test_multi_point();
      test_zero_cols();
      test_wb_stall();
      test_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
